// File: rtl/ram_bist_controller.sv
// March-style RAM self-test: write PATTERN up, verify up, write ~PATTERN down, verify down.
// Owns the RAM port while busy; reports the first failing address and the data read there.
module ram_bist_controller #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(8'hA5)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_W0   = 3'd1;
  localparam logic [2:0] S_R0   = 3'd2;
  localparam logic [2:0] S_W1   = 3'd3;
  localparam logic [2:0] S_R1   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] A_FIRST = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]      C_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]      C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      C_LAST  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      C_DRAIN = CNT_W'(DEPTH);

  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [DATA_WIDTH-1:0] r_fail_data;
  // Read data lags the address by one cycle, so the compared address is carried along.
  logic                  r_cmp_valid;
  logic [ADDR_WIDTH-1:0] r_cmp_addr;

  logic [DATA_WIDTH-1:0] w_expected;
  logic                  w_mismatch;

  // Expected read value for the current read phase and the mismatch flag.
  always_comb begin
    w_expected = PATTERN;
    w_mismatch = 1'b0;
    if (r_state == S_R1) begin
      w_expected = ~PATTERN;
    end else begin
      w_expected = PATTERN;
    end
    if (r_cmp_valid && (mem_rdata != w_expected)) begin
      w_mismatch = 1'b1;
    end else begin
      w_mismatch = 1'b0;
    end
  end

  // March sequencer; every output is produced from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= C_ZERO;
      r_addr      <= A_FIRST;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_addr <= A_FIRST;
      r_fail_data <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_addr  <= A_FIRST;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_W0;
            r_cnt       <= C_ZERO;
            r_addr      <= A_FIRST;
            r_we        <= 1'b1;
            r_wdata     <= PATTERN;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_fail_addr <= A_FIRST;
            r_fail_data <= '0;
          end else begin
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
          end
        end
        S_W0: begin
          if (r_cnt == C_LAST) begin
            r_state <= S_R0;
            r_cnt   <= C_ZERO;
            r_addr  <= A_FIRST;
            r_we    <= 1'b0;
            r_wdata <= '0;
          end else begin
            r_cnt  <= r_cnt + C_ONE;
            r_addr <= r_addr + A_ONE;
          end
        end
        S_R0, S_R1: begin
          if (w_mismatch) begin
            // Reads still in flight are dropped; only the first failure is kept.
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_addr      <= A_FIRST;
            r_cmp_valid <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= r_cmp_addr;
            r_fail_data <= mem_rdata;
          end else if (r_cnt == C_DRAIN) begin
            r_cnt       <= C_ZERO;
            r_cmp_valid <= 1'b0;
            if (r_state == S_R0) begin
              r_state <= S_W1;
              r_addr  <= A_LAST;
              r_we    <= 1'b1;
              r_wdata <= ~PATTERN;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_pass  <= 1'b1;
              r_addr  <= A_FIRST;
            end
          end else begin
            r_cnt       <= r_cnt + C_ONE;
            r_cmp_valid <= 1'b1;
            r_cmp_addr  <= r_addr;
            if (r_cnt == C_LAST) begin
              r_addr <= r_addr;
            end else if (r_state == S_R0) begin
              r_addr <= r_addr + A_ONE;
            end else begin
              r_addr <= r_addr - A_ONE;
            end
          end
        end
        S_W1: begin
          if (r_cnt == C_LAST) begin
            r_state <= S_R1;
            r_cnt   <= C_ZERO;
            r_addr  <= A_LAST;
            r_we    <= 1'b0;
            r_wdata <= '0;
          end else begin
            r_cnt  <= r_cnt + C_ONE;
            r_addr <= r_addr - A_ONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_we    <= 1'b0;
          r_wdata <= '0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_we        <= 1'b0;
          r_wdata     <= '0;
          r_cmp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail_addr   = r_fail_addr;
  assign fail_data   = r_fail_data;
  assign mem_address = r_addr;
  assign mem_we      = r_we;
  assign mem_wdata   = r_wdata;

endmodule

// File: tb/tb_ram_bist_controller.sv
// Directed bench for ram_bist_controller: fault-free, stuck-at, reset abort, held start, DEPTH=8 sweep.
module tb_ram_bist_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start4;
  logic       start8;

  logic       busy4, done4, pass4, we4;
  logic [1:0] faddr4, addr4;
  logic [7:0] fdata4, wdata4, rdata4;

  logic       busy8, done8, pass8, we8;
  logic [2:0] faddr8, addr8;
  logic [7:0] fdata8, wdata8, rdata8;

  ram_bist_controller #(.DATA_WIDTH(8), .DEPTH(4), .PATTERN(8'hA5)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4), .pass(pass4),
    .fail_addr(faddr4), .fail_data(fdata4), .mem_address(addr4), .mem_we(we4),
    .mem_wdata(wdata4), .mem_rdata(rdata4)
  );

  ram_bist_controller #(.DATA_WIDTH(8), .DEPTH(8), .PATTERN(8'h3C)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .busy(busy8), .done(done8), .pass(pass8),
    .fail_addr(faddr8), .fail_data(fdata8), .mem_address(addr8), .mem_we(we8),
    .mem_wdata(wdata8), .mem_rdata(rdata8)
  );

  // RAM models: synchronous read, optional stuck-at-0 bits on one address of the small RAM.
  logic [7:0] ram4 [0:3];
  logic [7:0] ram8 [0:7];
  int         f_addr;
  logic [7:0] f_mask;

  always @(posedge clk) begin
    if (we4) ram4[addr4] <= wdata4 & ((int'(addr4) == f_addr) ? ~f_mask : 8'hFF);
    rdata4 <= ram4[addr4];
  end

  always @(posedge clk) begin
    if (we8) ram8[addr8] <= wdata8;
    rdata8 <= ram8[addr8];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic       h_busy  [0:63];
  logic       h_done  [0:63];
  logic       h_pass  [0:63];
  logic       h_we    [0:63];
  logic [7:0] h_addr  [0:63];
  logic [7:0] h_wdata [0:63];
  logic [7:0] h_faddr [0:63];
  logic [7:0] h_fdata [0:63];

  // Cycle 1 is the period right after the edge that samples start.
  task automatic run(input bit use8, input int ncyc, input bit hold);
    if (use8) start8 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin start4 = 1'b0; start8 = 1'b0; end
    for (int i = 1; i <= ncyc; i++) begin
      h_busy[i]  = use8 ? busy8 : busy4;
      h_done[i]  = use8 ? done8 : done4;
      h_pass[i]  = use8 ? pass8 : pass4;
      h_we[i]    = use8 ? we8   : we4;
      h_addr[i]  = use8 ? 8'(addr8)  : 8'(addr4);
      h_wdata[i] = use8 ? wdata8     : wdata4;
      h_faddr[i] = use8 ? 8'(faddr8) : 8'(faddr4);
      h_fdata[i] = use8 ? fdata8     : fdata4;
      @(posedge clk); #1;
    end
  endtask

  function automatic int first_done(input int ncyc);
    for (int i = 1; i <= ncyc; i++) if (h_done[i]) return i;
    return -1;
  endfunction

  function automatic int count_busy(input int ncyc);
    int n = 0;
    for (int i = 1; i <= ncyc; i++) if (h_busy[i]) n++;
    return n;
  endfunction

  function automatic int count_we(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (h_we[i]) n++;
    return n;
  endfunction

  function automatic int count_bad_wdata(input int ncyc);
    int n = 0;
    for (int i = 1; i <= ncyc; i++) if (!h_we[i] && (h_wdata[i] != 8'h00)) n++;
    return n;
  endfunction

  initial begin
    reset  = 1'b1;
    start4 = 1'b0;
    start8 = 1'b0;
    f_addr = -1;
    f_mask = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outputs4", {busy4, done4, pass4, faddr4, fdata4, addr4, we4, wdata4}, 32'h0);
    check_val("rst_outputs8", {busy8, done8, pass8, faddr8, fdata8, addr8, we8, wdata8}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Scenario 1: fault-free DEPTH=4
    run(1'b0, 20, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("s1_w0_c%0d", 1 + k), {h_we[1+k], h_addr[1+k], h_wdata[1+k]}, {15'h0, 1'b1, 8'(k), 8'hA5});
      check_val($sformatf("s1_w1_c%0d", 10 + k), {h_we[10+k], h_addr[10+k], h_wdata[10+k]}, {15'h0, 1'b1, 8'(3 - k), 8'h5A});
    end
    check_val("s1_read_we", 32'(count_we(5, 9) + count_we(14, 20)), 32'd0);
    check_val("s1_done_cycle", 32'(first_done(20)), 32'd19);
    check_val("s1_busy_len", 32'(count_busy(20)), 32'd18);
    check_val("s1_busy_edges", {h_busy[1], h_busy[18], h_busy[19]}, 32'b110);
    check_val("s1_result", {h_pass[19], h_faddr[19], h_fdata[19]}, {15'h0, 1'b1, 8'h00, 8'h00});
    check_val("s1_wdata_idle0", 32'(count_bad_wdata(20)), 32'd0);
    check_val("s1_done_pulse", {h_done[18], h_done[20]}, 32'b00);

    // Scenario 2: address 2 bit 0 stuck-at-0
    f_addr = 2;
    f_mask = 8'h01;
    run(1'b0, 12, 1'b0);
    check_val("s2_done_cycle", 32'(first_done(12)), 32'd9);
    check_val("s2_result", {h_pass[9], h_faddr[9], h_fdata[9]}, {15'h0, 1'b0, 8'h02, 8'hA4});
    check_val("s2_no_late_writes", 32'(count_we(5, 12)), 32'd0);
    check_val("s2_busy_len", 32'(count_busy(12)), 32'd8);

    // Scenario 3: address 1 bit 1 stuck-at-0
    f_addr = 1;
    f_mask = 8'h02;
    run(1'b0, 20, 1'b0);
    check_val("s3_done_cycle", 32'(first_done(20)), 32'd18);
    check_val("s3_result", {h_pass[18], h_faddr[18], h_fdata[18]}, {15'h0, 1'b0, 8'h01, 8'h58});
    f_addr = -1;
    f_mask = 8'h00;

    // Scenario 4: reset during R0
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_val("s4_busy_c6", {busy4, addr4, we4}, {28'h0, 1'b1, 2'd1, 1'b0});
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("s4_outputs_c7", {busy4, done4, pass4, faddr4, fdata4, addr4, we4, wdata4}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("s4_idle_after", {busy4, we4}, 32'h0);
    run(1'b0, 20, 1'b0);
    check_val("s4_rerun_done", 32'(first_done(20)), 32'd19);
    check_val("s4_rerun_pass", {h_pass[19], h_faddr[19], h_fdata[19]}, {15'h0, 1'b1, 8'h00, 8'h00});

    // Scenario 5: start held high across two runs
    run(1'b0, 39, 1'b1);
    start4 = 1'b0;
    check_val("s5_first_done", 32'(first_done(39)), 32'd19);
    check_val("s5_busy_gap", {h_busy[18], h_busy[19], h_busy[20], h_busy[21]}, 32'b1001);
    check_val("s5_pass_cleared", {h_pass[19], h_pass[20], h_pass[21]}, 32'b110);
    check_val("s5_second_done", {h_done[38], h_done[39]}, 32'b01);
    check_val("s5_busy_total", 32'(count_busy(39)), 32'd36);
    check_val("s5_second_pass", 32'(h_pass[39]), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_val("s5_settled_idle", {busy4, we4}, 32'h0);

    // Scenario 6: DEPTH=8, PATTERN=3C
    run(1'b1, 40, 1'b0);
    check_val("s6_done_cycle", 32'(first_done(40)), 32'd35);
    check_val("s6_pass", {h_pass[35], h_faddr[35], h_fdata[35]}, {15'h0, 1'b1, 8'h00, 8'h00});
    check_val("s6_busy_len", 32'(count_busy(40)), 32'd34);
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("s6_w1_c%0d", 18 + k), {h_we[18+k], h_addr[18+k], h_wdata[18+k]}, {15'h0, 1'b1, 8'(7 - k), 8'hC3});
    end
    check_val("s6_w0_first", {h_we[1], h_addr[1], h_wdata[1]}, {15'h0, 1'b1, 8'h00, 8'h3C});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
